// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment scan driver: control-word layout,
// scan FSM encoding and the active-low hex glyph table.
package disp_pkg;

  localparam int unsigned EN_LSB    = 0;
  localparam int unsigned DP_LSB    = 8;
  localparam int unsigned BLANK_BIT = 16;

  typedef enum logic [1:0] {
    StInit,
    StGuard,
    StOn
  } state_e;

  // Segments {g,f,e,d,c,b,a}, active-low; element 15 is listed first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed 8-digit common-anode display driver. Shadows value/ctrl once per
// frame and scans one digit per DIV-cycle slot, each slot opening with GUARD blank cycles.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [31:0] ctrl,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD - 1);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [31:0]   val_sh_q;
  logic [16:0]   ctrl_sh_q;

  logic [3:0] nibble;
  logic [6:0] glyph;
  logic [7:0] en;
  logic [7:0] dp;
  logic       lit;
  logic       unused_ctrl;

  assign unused_ctrl = ^ctrl[31:17];

  assign nibble = val_sh_q[{idx_q, 2'b00} +: 4];
  assign en     = ctrl_sh_q[EN_LSB +: 8];
  assign dp     = ctrl_sh_q[DP_LSB +: 8];
  assign lit    = !ctrl_sh_q[BLANK_BIT] && en[idx_q];

  hex7seg u_hex7seg (
    .hex (nibble),
    .seg (glyph)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StInit;
      presc_q   <= '0;
      idx_q     <= '0;
      val_sh_q  <= '0;
      ctrl_sh_q <= '0;
      an        <= 8'hFF;
      seg       <= 7'h7F;
      dp_n      <= 1'b1;
      frame     <= 1'b0;
    end else begin
      // Outputs follow the state of the previous cycle, so blanking leads the anode switch.
      frame <= 1'b0;
      an    <= 8'hFF;
      seg   <= 7'h7F;
      dp_n  <= 1'b1;
      if (state_q == StOn) begin
        seg <= glyph;
        if (lit) begin
          an   <= ~(8'h01 << idx_q);
          dp_n <= ~dp[idx_q];
        end
      end

      case (state_q)
        StInit: begin
          val_sh_q  <= value;
          ctrl_sh_q <= ctrl[16:0];
          frame     <= 1'b1;
          idx_q     <= '0;
          presc_q   <= '0;
          state_q   <= StGuard;
        end
        StGuard: begin
          presc_q <= presc_q + 1'b1;
          if (presc_q == GUARD_LAST) state_q <= StOn;
        end
        StOn: begin
          if (presc_q == PRE_LAST) begin
            presc_q <= '0;
            state_q <= StGuard;
            if (idx_q == 3'd7) begin
              idx_q     <= '0;
              val_sh_q  <= value;
              ctrl_sh_q <= ctrl[16:0];
              frame     <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Randomized bench for disp_scan: two instances (DIV=8/GUARD=2 and DIV=2/GUARD=1)
// compared every cycle against a timeline model derived from slot arithmetic.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value;
  logic [31:0] ctrl;

  logic [7:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_n_a, dp_n_b;
  logic       frame_a, frame_b;

  disp_scan #(.DIV(8), .GUARD(2)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .ctrl  (ctrl),
    .an    (an_a),
    .seg   (seg_a),
    .dp_n  (dp_n_a),
    .frame (frame_a)
  );

  disp_scan #(.DIV(2), .GUARD(1)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .ctrl  (ctrl),
    .an    (an_b),
    .seg   (seg_b),
    .dp_n  (dp_n_b),
    .frame (frame_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          divs   [2] = '{8, 2};
  int          guards [2] = '{2, 1};
  int          kcnt   [2];
  logic [31:0] sh_val [2];
  logic [31:0] sh_ctrl[2];
  bit          in_reset;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // kk = clock edges since reset release; edge 1 and every 8*div after it capture.
  task automatic calc(input int div, input int guard, input int kk, input logic [31:0] sv,
                      input logic [31:0] sc, output logic [7:0] ean, output logic [6:0] eseg,
                      output logic edp, output logic efr);
    int t, d;
    ean  = 8'hFF;
    eseg = 7'h7F;
    edp  = 1'b1;
    efr  = (kk >= 1) && (((kk - 1) % (8 * div)) == 0);
    if (kk >= 2) begin
      t = kk - 2;
      d = (t / div) % 8;
      if ((t % div) >= guard) begin
        eseg = glyph_tab[sv[4*d +: 4]];
        if (!sc[16] && sc[d]) begin
          ean[d] = 1'b0;
          edp    = !sc[8+d];
        end
      end
    end
  endtask

  task automatic step();
    logic [7:0] ean;
    logic [6:0] eseg;
    logic       edp, efr;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!in_reset) kcnt[i]++;
      calc(divs[i], guards[i], kcnt[i], sh_val[i], sh_ctrl[i], ean, eseg, edp, efr);
      if (i == 0) begin
        check("a_an", {24'h0, an_a}, {24'h0, ean});
        check("a_seg", {25'h0, seg_a}, {25'h0, eseg});
        check("a_dp_n", {31'h0, dp_n_a}, {31'h0, edp});
        check("a_frame", {31'h0, frame_a}, {31'h0, efr});
      end else begin
        check("b_an", {24'h0, an_b}, {24'h0, ean});
        check("b_seg", {25'h0, seg_b}, {25'h0, eseg});
        check("b_dp_n", {31'h0, dp_n_b}, {31'h0, edp});
        check("b_frame", {31'h0, frame_b}, {31'h0, efr});
      end
      if (efr && !in_reset) begin
        sh_val[i]  = value;
        sh_ctrl[i] = ctrl;
      end
    end
  endtask

  task automatic run(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic wait_an_a(input logic [7:0] target, input string tag);
    bit found = 1'b0;
    for (int s = 0; s < 200 && !found; s++) begin
      step();
      if (an_a == target) found = 1'b1;
    end
    check(tag, {31'h0, found}, 32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      kcnt[i]    = 0;
      sh_val[i]  = '0;
      sh_ctrl[i] = '0;
    end
    in_reset = 1'b1;
    value    = 32'h7654_3210;
    ctrl     = 32'h0000_00FF;
    run(3);

    release_reset();
    for (int s = 1; s <= 70; s++) begin
      step();
      if (s == 1) check("init_frame", {31'h0, frame_a}, 32'd1);
      if (s == 3) check("guard_blank", {24'h0, an_a}, 32'hFF);
      if (s == 4) check("first_lit_an", {24'h0, an_a}, 32'hFE);
      if (s == 4) check("first_lit_seg", {25'h0, seg_a}, 32'h40);
      if (s == 65) check("frame_period", {31'h0, frame_a}, 32'd1);
    end

    wait_an_a(8'hF7, "wait_digit3");
    value = 32'hFFFF_FFFF;
    run(140);

    ctrl = 32'h0000_0305;
    run(130);
    ctrl = 32'h0001_0305;
    run(140);

    for (int r = 0; r < 6; r++) begin
      value = $urandom;
      ctrl  = $urandom;
      if (r != 4) ctrl[16] = 1'b0;
      run($urandom_range(20, 150));
      value = $urandom;
      run($urandom_range(10, 80));
    end

    ctrl  = 32'h0000_00FF;
    value = 32'h7654_3210;
    run(70);
    wait_an_a(8'hEF, "wait_digit4");
    rst = 1'b0;
    #1;
    check("async_an", {24'h0, an_a}, 32'hFF);
    check("async_seg", {25'h0, seg_a}, 32'h7F);
    check("async_dp_n", {31'h0, dp_n_a}, 32'd1);
    in_reset = 1'b1;
    kcnt[0]  = 0;
    kcnt[1]  = 0;
    value    = 32'hA5C3_9E10;
    run(3);
    release_reset();
    run(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
